// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_W              = 5;
    localparam int unsigned BUSY_CNT_W         = 4;
    localparam int unsigned STALL_CNT_W        = 16;
    localparam int unsigned MULDIV_LAT_DEFAULT = 8;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

    // One in-flight instruction as seen by the scoreboard
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             isload;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_BUBBLE = '0;

    // A load in EX whose result the instruction in ID needs right now
    function automatic logic load_use_hit(
        input shadow_entry_t    ex,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rs,
        input logic             uses_rt
    );
        logic src_hit;
        src_hit = (uses_rs && (ex.rd == rs)) || (uses_rt && (ex.rd == rt));
        return ex.valid && ex.isload && ex.regwrite && (ex.rd != REG_ZERO) && src_hit;
    endfunction

endpackage

// File: rtl/muldiv_busy_counter.sv
// Tracks how long the HI/LO unit remains busy after a mult/div issues.
module muldiv_busy_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT  // legal range 2..15
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    logic [BUSY_CNT_W-1:0] count;

    // Reload on an accepted mult/div, otherwise count down to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= BUSY_CNT_W'(0);
        end else if (load) begin
            count <= BUSY_CNT_W'(MULDIV_LAT);
        end else if (count != BUSY_CNT_W'(0)) begin
            count <= count - BUSY_CNT_W'(1);
        end
    end

    // Busy whenever any latency remains
    always_comb begin
        busy = (count != BUSY_CNT_W'(0));
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: load-use and HI/LO interlocks plus branch flush control.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_W-1:0]       ID_Rs,
    input  logic [REG_W-1:0]       ID_Rt,
    input  logic                   ID_UsesRs,
    input  logic                   ID_UsesRt,
    input  logic [REG_W-1:0]       ID_Rd,
    input  logic                   ID_RegWrite,
    input  logic                   ID_MemRead,
    input  logic                   ID_MulDiv,
    input  logic                   ID_ReadsHiLo,
    input  logic                   EX_BranchTaken,
    output logic                   PCWrite,
    output logic                   IF_ID_Write,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Flush,
    output logic                   MulDivBusy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam int unsigned EX_IDX       = 0;
    localparam int unsigned MEM_IDX      = 1;
    localparam int unsigned WB_IDX       = 2;
    localparam int unsigned SHADOW_DEPTH = 3;

    shadow_entry_t          shadow [SHADOW_DEPTH];
    shadow_entry_t          ex_next_c;
    logic                   busy_raw;
    logic                   load_use_c;
    logic                   hilo_hazard_c;
    logic                   stall_c;
    logic                   muldiv_accept_c;
    logic [STALL_CNT_W-1:0] stall_count_q;

    muldiv_busy_counter #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_busy (
        .clk   (clk),
        .reset (reset),
        .load  (muldiv_accept_c),
        .busy  (busy_raw)
    );

    // Hazard detection; reset forces a clean, non-stalling, non-flushing view
    always_comb begin
        MulDivBusy      = 1'b0;
        load_use_c      = 1'b0;
        hilo_hazard_c   = 1'b0;
        stall_c         = 1'b0;
        muldiv_accept_c = 1'b0;
        if (!reset) begin
            MulDivBusy      = busy_raw;
            load_use_c      = load_use_hit(shadow[EX_IDX], ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt);
            hilo_hazard_c   = busy_raw && (ID_ReadsHiLo || ID_MulDiv);
            stall_c         = (load_use_c || hilo_hazard_c) && !EX_BranchTaken;
            muldiv_accept_c = ID_MulDiv && !stall_c && !EX_BranchTaken;
        end
    end

    // Pipeline control; a taken branch wins over any stall
    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (!reset) begin
            PCWrite     = !stall_c;
            IF_ID_Write = !stall_c;
            IF_ID_Flush = EX_BranchTaken;
            ID_EX_Flush = stall_c || EX_BranchTaken;
        end
    end

    // Entry that follows the ID instruction into EX, or a bubble
    always_comb begin
        ex_next_c = SHADOW_BUBBLE;
        if (!stall_c && !EX_BranchTaken) begin
            ex_next_c.valid    = 1'b1;
            ex_next_c.rd       = ID_Rd;
            ex_next_c.regwrite = ID_RegWrite;
            ex_next_c.isload   = ID_MemRead;
        end
    end

    // Shadow pipeline advances every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow[EX_IDX]  <= SHADOW_BUBBLE;
            shadow[MEM_IDX] <= SHADOW_BUBBLE;
            shadow[WB_IDX]  <= SHADOW_BUBBLE;
        end else begin
            shadow[WB_IDX]  <= shadow[MEM_IDX];
            shadow[MEM_IDX] <= shadow[EX_IDX];
            shadow[EX_IDX]  <= ex_next_c;
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= STALL_CNT_W'(0);
        end else if (stall_c && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
            stall_count_q <= stall_count_q + STALL_CNT_W'(1);
        end
    end

    // Expose the stall counter
    always_comb begin
        StallCount = stall_count_q;
    end

endmodule
